// File: rtl/viterbi_decoder_pkg.sv
// Shared Viterbi decoder types, default sizing and the encoder-identical symbol function.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default K/RATE/FRAME_LEN, and the maximum sizes for the encode helper.
// The helper works on max-width operands; callers zero-extend, and zero taps contribute no output.
package viterbi_decoder_pkg;

  localparam int VD_K_DEF         = 3;
  localparam int VD_RATE_DEF      = 2;
  localparam int VD_FRAME_LEN_DEF = 16;

  localparam int VD_K_MAX    = 8;
  localparam int VD_RATE_MAX = 4;

  typedef enum logic [1:0] {
    VD_IDLE,
    VD_ACS,
    VD_TRACE,
    VD_OUTPUT
  } vd_state_e;

  typedef logic [VD_RATE_MAX-1:0][VD_K_MAX-1:0] vd_poly_t;

  // mux = {state, new_bit}: new bit at position 0.
  // Output bit i = parity of (mux & g[i]).
  function automatic logic [VD_RATE_MAX-1:0] vd_encode(input vd_poly_t g,
                                                       input logic [VD_K_MAX-1:0] mux);
    logic [VD_RATE_MAX-1:0] sym;
    sym = '0;
    for (int i = 0; i < VD_RATE_MAX; i++) begin
      sym[i] = ^(g[i] & mux);
    end
    return sym;
  endfunction

endpackage

// File: rtl/viterbi_decoder_acs_unit.sv
// Combinational add-compare-select for one trellis state.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent decides when the result is captured.
// Ports: gen_poly/code_data (current symbol context), pm0/pm1 (metrics of predecessors x=0/1),
//        pm_new (survivor metric, saturating), surv (selected predecessor MSB, x).
module vd_acs_unit
  import viterbi_decoder_pkg::*;
#(
  parameter int K     = VD_K_DEF,
  parameter int RATE  = VD_RATE_DEF,
  parameter int MET_W = 6,
  parameter int STATE = 0
) (
  input  logic [RATE-1:0][K-1:0] gen_poly,
  input  logic [RATE-1:0]        code_data,
  input  logic [MET_W-1:0]       pm0,
  input  logic [MET_W-1:0]       pm1,
  output logic [MET_W-1:0]       pm_new,
  output logic                   surv
);

  localparam int BM_W = $clog2(VD_RATE_MAX + 1);
  localparam logic [K-2:0] N = (K-1)'(STATE);

  vd_poly_t               g_ext;
  logic [VD_K_MAX-1:0]    mux0;
  logic [VD_K_MAX-1:0]    mux1;
  logic [VD_RATE_MAX-1:0] code_ext;
  logic [VD_RATE_MAX-1:0] d0;
  logic [VD_RATE_MAX-1:0] d1;
  logic [BM_W-1:0]        bm0;
  logic [BM_W-1:0]        bm1;
  logic [MET_W:0]         sum0;
  logic [MET_W:0]         sum1;
  logic [MET_W-1:0]       c0;
  logic [MET_W-1:0]       c1;

  always_comb begin
    g_ext = '0;
    for (int i = 0; i < RATE; i++) begin
      g_ext[i][K-1:0] = gen_poly[i];
    end
    // Predecessor {x, N[K-2:1]} shifted by input bit N[0] gives register {x, N}.
    mux0     = VD_K_MAX'({1'b0, N});
    mux1     = VD_K_MAX'({1'b1, N});
    code_ext = VD_RATE_MAX'(code_data);
    d0       = code_ext ^ vd_encode(g_ext, mux0);
    d1       = code_ext ^ vd_encode(g_ext, mux1);
    bm0      = '0;
    bm1      = '0;
    for (int i = 0; i < VD_RATE_MAX; i++) begin
      bm0 = bm0 + BM_W'(d0[i]);
      bm1 = bm1 + BM_W'(d1[i]);
    end
    sum0 = {1'b0, pm0} + (MET_W+1)'(bm0);
    sum1 = {1'b0, pm1} + (MET_W+1)'(bm1);
    c0   = sum0[MET_W] ? '1 : sum0[MET_W-1:0];
    c1   = sum1[MET_W] ? '1 : sum1[MET_W-1:0];
    // Strictly-less picks x=1, so a tie resolves to x=0.
    surv   = (c1 < c0);
    pm_new = surv ? c1 : c0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision radix-2 Viterbi decoder for zero-terminated fixed-length frames.
// Latency: first o_dec_valid FRAME_LEN+1 cycles after the last symbol is accepted.
// Backpressure: o_ready high in IDLE/ACS, low during TRACE/OUTPUT; i_code_valid is ignored there.
// Ports: clk, rst (async active-low), en_vd (low aborts to IDLE), i_gen_poly[RATE][K],
//        i_code_data/i_code_valid/o_ready (symbol input), o_dec_bit/o_dec_valid/o_frame_done (output),
//        o_busy (not IDLE), o_err_cnt (only when VD_ERR_COUNT_EN is defined: final metric of state 0).
module viterbi_decoder
  import viterbi_decoder_pkg::*;
#(
  parameter int  K         = VD_K_DEF,
  parameter int  RATE      = VD_RATE_DEF,
  parameter int  FRAME_LEN = VD_FRAME_LEN_DEF,
  localparam int MET_W     = $clog2(RATE*FRAME_LEN+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_vd,
  input  logic [RATE-1:0][K-1:0] i_gen_poly,
  input  logic [RATE-1:0]        i_code_data,
  input  logic                   i_code_valid,
  output logic                   o_ready,
  output logic                   o_dec_bit,
  output logic                   o_dec_valid,
  output logic                   o_frame_done,
  output logic                   o_busy
`ifdef VD_ERR_COUNT_EN
  ,
  output logic [MET_W-1:0]       o_err_cnt
`endif
);

  localparam int SW    = K - 1;
  localparam int NS    = 1 << SW;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  vd_state_e              state_q;
  vd_state_e              state_d;
  logic                   ready_q;
  logic [RATE-1:0][K-1:0] gen_q;
  logic [RATE-1:0][K-1:0] poly_sel;
  logic [CNT_W-1:0]       cnt_q;
  logic [SW-1:0]          ts_q;
  logic [FRAME_LEN-1:0]   out_buf;
  logic [MET_W-1:0]       pm_q   [NS];
  logic [MET_W-1:0]       pm_new [NS];
  logic [NS-1:0]          surv_new;
  logic [NS-1:0]          surv_mem [FRAME_LEN];
  logic                   accept;
  logic                   last_row;

  // ready_q only ever reflects IDLE/ACS, so it already implies an accepting state.
  assign accept   = i_code_valid & ready_q & en_vd;
  assign last_row = (cnt_q == LAST);
  assign o_ready  = ready_q;
  // Step 0 uses the live polynomials; they are latched on that same edge.
  assign poly_sel = (state_q == VD_IDLE) ? i_gen_poly : gen_q;

  for (genvar n = 0; n < NS; n++) begin : g_acs
    localparam int P0 = n >> 1;
    localparam int P1 = (n >> 1) | (1 << (SW - 1));
    vd_acs_unit #(
      .K     (K),
      .RATE  (RATE),
      .MET_W (MET_W),
      .STATE (n)
    ) u_acs (
      .gen_poly  (poly_sel),
      .code_data (i_code_data),
      .pm0       (pm_q[P0]),
      .pm1       (pm_q[P1]),
      .pm_new    (pm_new[n]),
      .surv      (surv_new[n])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= VD_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    o_dec_valid  = 1'b0;
    o_dec_bit    = 1'b0;
    o_frame_done = 1'b0;
    o_busy       = (state_q != VD_IDLE);
    case (state_q)
      VD_IDLE:  if (accept) state_d = VD_ACS;
      VD_ACS:   if (accept && last_row) state_d = VD_TRACE;
      VD_TRACE: if (cnt_q == '0) state_d = VD_OUTPUT;
      VD_OUTPUT: begin
        o_dec_valid  = 1'b1;
        o_dec_bit    = out_buf[cnt_q];
        o_frame_done = last_row;
        if (last_row) state_d = VD_IDLE;
      end
      default: state_d = VD_IDLE;
    endcase
    if (!en_vd) state_d = VD_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      gen_q   <= '0;
      cnt_q   <= '0;
      ts_q    <= '0;
      out_buf <= '0;
      for (int n = 0; n < NS; n++) pm_q[n] <= (n == 0) ? '0 : '1;
    end else begin
      ready_q <= (state_d == VD_IDLE) || (state_d == VD_ACS);
      if (state_d == VD_IDLE) begin
        // Covers abort, frame end and idling: start point is state 0 only.
        cnt_q <= '0;
        for (int n = 0; n < NS; n++) pm_q[n] <= (n == 0) ? '0 : '1;
      end else begin
        case (state_q)
          VD_IDLE, VD_ACS: begin
            if (accept) begin
              for (int n = 0; n < NS; n++) pm_q[n] <= pm_new[n];
              if (state_q == VD_IDLE) gen_q <= i_gen_poly;
              // On the last row cnt_q is left at FRAME_LEN-1, the first traceback row.
              if (last_row) ts_q  <= '0;
              else          cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          VD_TRACE: begin
            out_buf[cnt_q] <= ts_q[0];
            ts_q           <= {surv_mem[cnt_q][ts_q], ts_q[SW-1:1]};
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          end
          VD_OUTPUT: cnt_q <= cnt_q + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Survivor rows need no reset: every row is rewritten before traceback reads it.
  always_ff @(posedge clk) begin
    if (accept) surv_mem[cnt_q] <= surv_new;
  end

`ifdef VD_ERR_COUNT_EN
  logic [MET_W-1:0] err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        err_q <= '0;
    else if (state_q == VD_ACS && accept && last_row) err_q <= pm_new[0];
  end
  assign o_err_cnt = err_q;
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder (K=3, g0=111, g1=101, FRAME_LEN=16).
// Latency: n/a.
// Backpressure: symbols are held until o_ready.
`timescale 1ns/1ps
module tb_viterbi_decoder;

  localparam int K     = 3;
  localparam int RATE  = 2;
  localparam int FL    = 16;
  localparam int MET_W = $clog2(RATE*FL+1);
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en_vd;
  logic [RATE-1:0][K-1:0] gen_poly;
  logic [RATE-1:0]        code_data;
  logic                   code_valid;
  logic                   ready;
  logic                   dec_bit;
  logic                   dec_valid;
  logic                   frame_done;
  logic                   busy;
`ifdef VD_ERR_COUNT_EN
  logic [MET_W-1:0]       err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  viterbi_decoder #(.K(K), .RATE(RATE), .FRAME_LEN(FL)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_vd        (en_vd),
    .i_gen_poly   (gen_poly),
    .i_code_data  (code_data),
    .i_code_valid (code_valid),
    .o_ready      (ready),
    .o_dec_bit    (dec_bit),
    .o_dec_valid  (dec_valid),
    .o_frame_done (frame_done),
    .o_busy       (busy)
`ifdef VD_ERR_COUNT_EN
    ,
    .o_err_cnt    (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference encoder straight from the trellis rules: window of the newest three data bits
  // (earlier bits zero), newest bit at tap 0; symbol t occupies bits [2t+1:2t], bit 0 = g0.
  function automatic logic [2*FL-1:0] encode_frame(input logic [FL-1:0] d);
    logic [2*FL-1:0] s;
    logic [FL+1:0]   ext;
    logic [2:0]      w;
    logic [2:0]      mux;
    s   = '0;
    ext = {d, 2'b00};
    for (int t = 0; t < FL; t++) begin
      w          = ext[t +: 3];
      mux        = {w[0], w[1], w[2]};
      s[2*t]     = ^(mux & G0);
      s[2*t+1]   = ^(mux & G1);
    end
    return s;
  endfunction

  // Sends the first n symbols of f starting at a negedge; optional stall before symbol stall_at.
  // Returns at the negedge right after the edge that accepted the last symbol.
  task automatic send_frame(input logic [2*FL-1:0] f, input int stall_at, input int stall_len,
                            input int n);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        code_valid = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      code_valid = 1'b1;
      code_data  = f[2*i +: 2];
      for (int g = 0; g < 20 && !ready; g++) @(negedge clk);
      if (!ready) chk("ready_before_accept", ready, 1);
      @(posedge clk);
      @(negedge clk);
    end
    code_valid = 1'b0;
  endtask

  // Called at the negedge after the last accept (cycle 1); junk drives ignored symbols.
  task automatic collect(input string tag, input logic [FL-1:0] exp, input int exp_err,
                         input bit junk);
    int k;
    k = 1;
    chk({tag, "_ready_low"}, ready, 0);
    chk({tag, "_busy"}, busy, 1);
    while (!dec_valid && k < 100) begin
      if (junk) begin
        code_valid = 1'b1;
        code_data  = 2'($urandom);
      end
      @(negedge clk);
      k++;
    end
    code_valid = 1'b0;
    chk({tag, "_latency"}, k, FL + 1);
    for (int i = 0; i < FL; i++) begin
      chk({tag, "_valid"}, dec_valid, 1);
      chk({tag, "_bit"}, dec_bit, exp[i]);
      chk({tag, "_done"}, frame_done, (i == FL - 1) ? 1 : 0);
      @(negedge clk);
    end
    chk({tag, "_valid_after"}, dec_valid, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_ready_after"}, ready, 1);
`ifdef VD_ERR_COUNT_EN
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
`else
    if (exp_err < 0) chk({tag, "_exp_err_range"}, exp_err, 0);
`endif
  endtask

  initial begin
    logic [2*FL-1:0] f;
    logic [FL-1:0]   d;
    int nerr, p1, p2, k;

    rst        = 1'b0;
    en_vd      = 1'b1;
    code_valid = 1'b0;
    code_data  = '0;
    gen_poly[0] = G0;
    gen_poly[1] = G1;

    // Reset state
    #12;
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", dec_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_bit", dec_bit, 0);
`ifdef VD_ERR_COUNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);

    // All-zero frame
    send_frame('0, -1, 0, FL);
    collect("zero", '0, 0, 1'b0);

    // Listed symbol vector for data 1,0,1,1
    send_frame(32'h0000_0E87, -1, 0, FL);
    collect("d1011", 16'h000D, 0, 1'b0);

    // Same frame, symbol 2 received as 01
    send_frame(32'h0000_0E97, -1, 0, FL);
    collect("d1011_err", 16'h000D, 1, 1'b0);

    // Five stall cycles mid-frame; symbols offered during traceback must be ignored
    send_frame(32'h0000_0E87, 7, 5, FL);
    collect("stall", 16'h000D, 0, 1'b1);

    // Abort after 8 symbols of a busy frame, then a clean all-zero frame
    send_frame(encode_frame(16'h3A5B), -1, 0, 8);
    chk("abort_busy_before", busy, 1);
    en_vd = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", dec_valid, 0);
    en_vd = 1'b1;
    @(negedge clk);
    send_frame('0, -1, 0, FL);
    collect("after_abort", '0, 0, 1'b0);

    // Random frames with up to two channel errors (free distance 5 makes them correctable)
    for (int r = 0; r < 8; r++) begin
      d    = {2'b00, 14'($urandom)};
      f    = encode_frame(d);
      nerr = int'($urandom_range(0, 2));
      p1   = int'($urandom_range(0, 2*FL-1));
      p2   = (p1 + int'($urandom_range(1, 2*FL-1))) % (2*FL);
      if (nerr >= 1) f[p1] = ~f[p1];
      if (nerr == 2) f[p2] = ~f[p2];
      send_frame(f, int'($urandom_range(0, FL-1)), int'($urandom_range(0, 3)), FL);
      collect("rand", d, nerr, 1'b1);
    end

    // Reset asserted during OUTPUT
    send_frame(encode_frame(16'h000D), -1, 0, FL);
    for (k = 0; k < 60 && !dec_valid; k++) @(negedge clk);
    chk("midout_valid_seen", dec_valid, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midout_rst_valid", dec_valid, 0);
    chk("midout_rst_busy", busy, 0);
    chk("midout_rst_done", frame_done, 0);
    chk("midout_rst_ready", ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midout_ready_after", ready, 1);
    chk("midout_busy_after", busy, 0);

    // Decoder still healthy after the reset
    d = 16'h2C71;
    send_frame(encode_frame(d), -1, 0, FL);
    collect("post_reset", d, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
